// File: rtl/uart_rx_os.sv
// uart_rx_os -- oversampled UART receiver.
//
// The receiver takes a one-clock os_tick strobe running at OS_RATE times
// the baud rate. It locks onto the falling edge of the start bit and samples
// each bit at its mid-point, which gives the largest margin against baud
// mismatch and edge jitter.
//
// Frame format: start (0), DATA_BITS data bits LSB first, an optional
// parity bit, then STOP_BITS stop bits (1).
//
// When the final stop bit has been sampled, the word is presented on
// data_out together with a one-clock data_valid pulse. The parity_err and
// frame_err pulses are asserted in that same cycle.
//
// If a frame ends with the line still low (a break, or a stuck line), the
// receiver parks in BREAK. It does not hunt for a new start bit until the
// line returns high, so a long low level cannot be misread as a string of
// 0x00 frames.

module uart_rx_os #(
  parameter int DATA_BITS  = 8,   // 5..9
  parameter int OS_RATE    = 16,  // even, 8..32
  parameter int PARITY_EN  = 0,   // 1 = parity bit after the data bits
  parameter int PARITY_ODD = 0,   // 1 = odd parity, 0 = even parity
  parameter int STOP_BITS  = 1    // 1..2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 os_tick,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  // ---------------------------------------------------------------------
  // Derived sizes and constants
  // ---------------------------------------------------------------------
  localparam int OS_W  = $clog2(OS_RATE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  // The start bit is qualified after OS_RATE/2 ticks, i.e. at its centre.
  // Every later bit is sampled one full bit period (OS_RATE ticks) after
  // that, so it is also sampled at its centre.
  localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OS_RATE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OS_RATE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);
  localparam logic             HAS_PAR   = (PARITY_EN != 0);

  // FSM encoding
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic                 rx_meta;
  logic                 rx_s;
  logic [2:0]           state;
  logic [OS_W-1:0]      os_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_flag;   // parity mismatch seen in this frame
  logic                 stop_flag;  // an earlier stop bit sampled low

  // Strobes marking the sampling instants within the current bit.
  logic start_mid;
  logic bit_mid;

  assign start_mid = os_tick && (os_cnt == OS_MID);
  assign bit_mid   = os_tick && (os_cnt == OS_LAST);

  assign busy = (state != IDLE);

  // Two-flop synchronizer for the asynchronous serial line. Both flops
  // reset to the idle (high) level, so no false start is seen after reset.
  // NOTE: non-blocking assignments make rx_meta -> rx_s a true two-stage
  // shift; blocking here would collapse both flops into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM: start qualification, bit timing, shifting, checks, output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_flag   <= 1'b0;
      stop_flag  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // The completion pulses default low, so each can last only one clock.
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        // The line is watched on every clock, not only on ticks, so the
        // bit timing starts from the first clock that shows the edge.
        IDLE: begin
          if (!rx_s) begin
            state     <= START;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            par_flag  <= 1'b0;
            stop_flag <= 1'b0;
          end
        end

        // Confirm the start bit at its centre. If the line is high again
        // by then, the low level was a glitch and is dropped silently.
        START: begin
          if (os_tick) begin
            if (start_mid) begin
              os_cnt <= '0;
              state  <= rx_s ? IDLE : DATA;
            end else begin
              os_cnt <= os_cnt + OS_W'(1);
            end
          end
        end

        // Shift in the data bits, LSB first. After the last data bit the
        // frame continues with the parity bit if enabled, else the stop bits.
        DATA: begin
          if (os_tick) begin
            if (bit_mid) begin
              os_cnt    <= '0;
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                state   <= HAS_PAR ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end else begin
              os_cnt <= os_cnt + OS_W'(1);
            end
          end
        end

        // Check the parity bit. The XOR of the data bits and the parity bit
        // must equal 1 for odd parity and 0 for even parity.
        PARITY: begin
          if (os_tick) begin
            if (bit_mid) begin
              os_cnt   <= '0;
              par_flag <= ((^shift_reg) ^ rx_s) != PAR_ODD;
              state    <= STOP;
            end else begin
              os_cnt <= os_cnt + OS_W'(1);
            end
          end
        end

        // Check the stop bits. The word is always delivered, even when an
        // error is flagged. If the line is still low at the final sample,
        // the receiver goes to BREAK instead of treating that low as a
        // new start bit.
        STOP: begin
          if (os_tick) begin
            if (bit_mid) begin
              os_cnt <= '0;
              if (bit_cnt == STOP_LAST) begin
                bit_cnt    <= '0;
                data_out   <= shift_reg;
                data_valid <= 1'b1;
                parity_err <= par_flag;
                frame_err  <= stop_flag | ~rx_s;
                state      <= ((stop_flag | ~rx_s) && !rx_s) ? BREAK : IDLE;
              end else begin
                bit_cnt   <= bit_cnt + BIT_W'(1);
                stop_flag <= stop_flag | ~rx_s;
              end
            end else begin
              os_cnt <= os_cnt + OS_W'(1);
            end
          end
        end

        // Wait for the line to return high before looking for a start bit.
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os -- directed testbench for uart_rx_os.
//
// Three receivers share one clock, one tick generator and one reset:
//   u_def : default parameters (8N1)
//   u_par : even parity enabled (8E1)
//   u_s2  : two stop bits (8N2)
// Each receiver has its own rx line. A monitor records every data_valid
// pulse and every error pulse that arrives without data_valid.

module tb_uart_rx_os;

  localparam int OS_RATE  = 16;
  localparam int TICK_DIV = 4;                  // clocks per os_tick
  localparam int BIT_CLKS = OS_RATE * TICK_DIV; // clocks per bit

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic os_tick = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic rx_c = 1'b1;

  logic [7:0] d_a, d_b, d_c;
  logic dv_a, dv_b, dv_c;
  logic pe_a, pe_b, pe_c;
  logic fe_a, fe_b, fe_c;
  logic busy_a, busy_b, busy_c;

  int checks = 0;
  int errors = 0;

  uart_rx_os u_def (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .os_tick(os_tick),
    .data_out(d_a), .data_valid(dv_a), .parity_err(pe_a),
    .frame_err(fe_a), .busy(busy_a)
  );

  uart_rx_os #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .os_tick(os_tick),
    .data_out(d_b), .data_valid(dv_b), .parity_err(pe_b),
    .frame_err(fe_b), .busy(busy_b)
  );

  uart_rx_os #(.STOP_BITS(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .rx(rx_c), .os_tick(os_tick),
    .data_out(d_c), .data_valid(dv_c), .parity_err(pe_c),
    .frame_err(fe_c), .busy(busy_c)
  );

  always #5 clk = ~clk;

  // Tick generator: one os_tick in every TICK_DIV clocks.
  int div = 0;
  always @(negedge clk) begin
    os_tick = (div == TICK_DIV - 1);
    div = (div == TICK_DIV - 1) ? 0 : div + 1;
  end

  // Monitor: per-instance counts of valid pulses, the last captured word and
  // flags, and counts of error pulses that arrive without data_valid.
  int         vcnt[3];
  int         stray[3];
  logic [7:0] last_d[3];
  logic       last_pe[3];
  logic       last_fe[3];
  logic [7:0] q_a[$];

  initial begin
    for (int i = 0; i < 3; i++) begin
      vcnt[i] = 0; stray[i] = 0; last_d[i] = '0; last_pe[i] = 0; last_fe[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (dv_a) begin
      vcnt[0]++; last_d[0] = d_a; last_pe[0] = pe_a; last_fe[0] = fe_a; q_a.push_back(d_a);
    end else if (pe_a || fe_a) stray[0]++;
    if (dv_b) begin
      vcnt[1]++; last_d[1] = d_b; last_pe[1] = pe_b; last_fe[1] = fe_b;
    end else if (pe_b || fe_b) stray[1]++;
    if (dv_c) begin
      vcnt[2]++; last_d[2] = d_c; last_pe[2] = pe_c; last_fe[2] = fe_c;
    end else if (pe_c || fe_c) stray[2]++;
  end

  task automatic set_rx(input int line, input logic v);
    case (line)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Send n bits, bits[0] first, each bit held for one full bit time.
  task automatic send(input int line, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(line, bits[i]);
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    if ({d_a, dv_a, pe_a, fe_a, busy_a} !== 12'h000) begin
      $display("FAIL reset_outputs got %h exp 000", {d_a, dv_a, pe_a, fe_a, busy_a});
      errors++;
    end
    checks++;
    rst_n = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    if (busy_a !== 1'b0) begin
      $display("FAIL reset_idle_busy got %b exp 0", busy_a); errors++;
    end
    checks++;
  endtask

  task automatic test_basic;
    int v0;
    logic [15:0] f;
    v0 = vcnt[0];
    f  = 16'({1'b1, 8'hA5, 1'b0});
    send(0, f, 5);
    if (busy_a !== 1'b1) begin
      $display("FAIL basic_busy_mid got %b exp 1", busy_a); errors++;
    end
    checks++;
    send(0, f >> 5, 5);
    if (vcnt[0] !== v0 + 1) begin
      $display("FAIL basic_valid_count got %0d exp %0d", vcnt[0], v0 + 1); errors++;
    end
    checks++;
    if (last_d[0] !== 8'hA5 || d_a !== 8'hA5) begin
      $display("FAIL basic_data got %h/%h exp a5", last_d[0], d_a); errors++;
    end
    checks++;
    if (last_pe[0] !== 1'b0 || last_fe[0] !== 1'b0) begin
      $display("FAIL basic_err got pe=%b fe=%b exp 0 0", last_pe[0], last_fe[0]); errors++;
    end
    checks++;
    if (busy_a !== 1'b0) begin
      $display("FAIL basic_busy_after got %b exp 0", busy_a); errors++;
    end
    checks++;
  endtask

  task automatic test_glitch;
    int v0;
    v0 = vcnt[0];
    set_rx(0, 1'b0);
    repeat (8) @(negedge clk);
    if (busy_a !== 1'b1) begin
      $display("FAIL glitch_busy_in got %b exp 1", busy_a); errors++;
    end
    checks++;
    repeat (8) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (48) @(negedge clk);
    if (busy_a !== 1'b0) begin
      $display("FAIL glitch_busy_after got %b exp 0", busy_a); errors++;
    end
    checks++;
    if (vcnt[0] !== v0) begin
      $display("FAIL glitch_no_valid got %0d exp %0d", vcnt[0], v0); errors++;
    end
    checks++;
  endtask

  task automatic test_parity;
    int v0;
    v0 = vcnt[1];
    // 0x03 has two ones; an even-parity bit of 1 is wrong.
    send(1, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11);
    if (vcnt[1] !== v0 + 1 || last_d[1] !== 8'h03) begin
      $display("FAIL parity_bad_data got cnt=%0d d=%h exp cnt=%0d d=03", vcnt[1], last_d[1], v0 + 1);
      errors++;
    end
    checks++;
    if (last_pe[1] !== 1'b1 || last_fe[1] !== 1'b0) begin
      $display("FAIL parity_bad_flags got pe=%b fe=%b exp 1 0", last_pe[1], last_fe[1]); errors++;
    end
    checks++;
    // 0x07 has three ones; an even-parity bit of 1 is correct.
    send(1, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
    if (last_d[1] !== 8'h07 || last_pe[1] !== 1'b0) begin
      $display("FAIL parity_good got d=%h pe=%b exp 07 0", last_d[1], last_pe[1]); errors++;
    end
    checks++;
  endtask

  task automatic test_break;
    int v0;
    v0 = vcnt[0];
    send(0, 16'({1'b0, 8'h00, 1'b0}), 10);
    repeat (BIT_CLKS) @(negedge clk);
    if (vcnt[0] !== v0 + 1 || last_d[0] !== 8'h00 || last_fe[0] !== 1'b1) begin
      $display("FAIL break_frame got cnt=%0d d=%h fe=%b exp cnt=%0d d=00 fe=1",
               vcnt[0], last_d[0], last_fe[0], v0 + 1);
      errors++;
    end
    checks++;
    repeat (19 * BIT_CLKS) @(negedge clk);
    if (busy_a !== 1'b1 || vcnt[0] !== v0 + 1) begin
      $display("FAIL break_hold got busy=%b cnt=%0d exp busy=1 cnt=%0d", busy_a, vcnt[0], v0 + 1);
      errors++;
    end
    checks++;
    set_rx(0, 1'b1);
    repeat (8) @(negedge clk);
    if (busy_a !== 1'b0) begin
      $display("FAIL break_release got %b exp 0", busy_a); errors++;
    end
    checks++;
    repeat (BIT_CLKS) @(negedge clk);
    send(0, 16'({1'b1, 8'h3C, 1'b0}), 10);
    if (vcnt[0] !== v0 + 2 || last_d[0] !== 8'h3C || last_fe[0] !== 1'b0 || last_pe[0] !== 1'b0) begin
      $display("FAIL break_next got cnt=%0d d=%h fe=%b pe=%b exp cnt=%0d d=3c 0 0",
               vcnt[0], last_d[0], last_fe[0], last_pe[0], v0 + 2);
      errors++;
    end
    checks++;
  endtask

  task automatic test_stop2;
    int v0;
    v0 = vcnt[2];
    // First stop bit high, second stop bit low.
    send(2, 16'({1'b0, 1'b1, 8'h81, 1'b0}), 11);
    set_rx(2, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    if (vcnt[2] !== v0 + 1 || last_d[2] !== 8'h81 || last_fe[2] !== 1'b1) begin
      $display("FAIL stop2_err got cnt=%0d d=%h fe=%b exp cnt=%0d d=81 fe=1",
               vcnt[2], last_d[2], last_fe[2], v0 + 1);
      errors++;
    end
    checks++;
    send(2, 16'({1'b1, 1'b1, 8'h7E, 1'b0}), 11);
    if (vcnt[2] !== v0 + 2 || last_d[2] !== 8'h7E || last_fe[2] !== 1'b0) begin
      $display("FAIL stop2_clean got cnt=%0d d=%h fe=%b exp cnt=%0d d=7e fe=0",
               vcnt[2], last_d[2], last_fe[2], v0 + 2);
      errors++;
    end
    checks++;
  endtask

  task automatic test_back_to_back;
    q_a.delete();
    send(0, 16'({1'b1, 8'h11, 1'b0}), 10);
    send(0, 16'({1'b1, 8'h22, 1'b0}), 10);
    if (q_a.size() !== 2) begin
      $display("FAIL b2b_count got %0d exp 2", q_a.size()); errors++;
    end else if (q_a[0] !== 8'h11 || q_a[1] !== 8'h22) begin
      $display("FAIL b2b_order got %h %h exp 11 22", q_a[0], q_a[1]); errors++;
    end
    checks++;
    if (last_fe[0] !== 1'b0 || last_pe[0] !== 1'b0) begin
      $display("FAIL b2b_err got fe=%b pe=%b exp 0 0", last_fe[0], last_pe[0]); errors++;
    end
    checks++;
  endtask

  task automatic test_reset_mid;
    int v0;
    v0 = vcnt[0];
    // Start bit and data bits 0..3 of 0xFF, then half of data bit 4.
    send(0, 16'({1'b1, 8'hFF, 1'b0}), 5);
    set_rx(0, 1'b1);
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    if ({d_a, dv_a, pe_a, fe_a, busy_a} !== 12'h000 || d_c !== 8'h00) begin
      $display("FAIL reset_mid_outputs got %h/%h exp 000/00", {d_a, dv_a, pe_a, fe_a, busy_a}, d_c);
      errors++;
    end
    checks++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // Remainder of the abandoned frame: the line stays high.
    repeat (BIT_CLKS * 4) @(negedge clk);
    if (vcnt[0] !== v0 || busy_a !== 1'b0) begin
      $display("FAIL reset_mid_abandon got cnt=%0d busy=%b exp cnt=%0d busy=0", vcnt[0], busy_a, v0);
      errors++;
    end
    checks++;
    send(0, 16'({1'b1, 8'h5A, 1'b0}), 10);
    if (vcnt[0] !== v0 + 1 || last_d[0] !== 8'h5A || last_fe[0] !== 1'b0) begin
      $display("FAIL reset_mid_next got cnt=%0d d=%h fe=%b exp cnt=%0d d=5a fe=0",
               vcnt[0], last_d[0], last_fe[0], v0 + 1);
      errors++;
    end
    checks++;
  endtask

  task automatic test_stray;
    for (int i = 0; i < 3; i++) begin
      if (stray[i] !== 0) begin
        $display("FAIL stray_err_pulse inst %0d got %0d exp 0", i, stray[i]); errors++;
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_break();
    test_stop2();
    test_back_to_back();
    test_reset_mid();
    test_stray();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
